// File: rtl/om_port_arbiter.sv
// Single-port arbiter/sequencer for the 16x64 output memory: init sweep, datapath
// writes, accumulate bursts and host readback share one registered memory port.
module om_port_arbiter #(
    parameter int AW     = 4,
    parameter int DW     = 64,
    parameter int STARVE = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          CLR_DP,
    input  logic          DP_WE,
    input  logic [AW-1:0] DP_ADDR,
    input  logic [DW-1:0] DP_WDATA,
    output logic          DP_STALL,
    input  logic          WB_REQ,
    input  logic [2:0]    WB_LEN,
    output logic          WB_GNT,
    input  logic          WB_EN,
    input  logic [AW-1:0] WB_ADDR,
    input  logic [DW-1:0] WB_DATA,
    output logic          WB_DONE,
    input  logic          HOST_RD,
    input  logic [AW-1:0] HOST_ADDR,
    output logic          HOST_RVALID,
    output logic [DW-1:0] HOST_RDATA,
    output logic          OM_EN,
    output logic          OM_WE,
    output logic [AW-1:0] OM_ADDR,
    output logic [DW-1:0] OM_WDATA,
    input  logic [DW-1:0] OM_RDATA,
    output logic [1:0]    OMSRC,
    output logic          INIT_DONE
);

    localparam int AGE_W = $clog2(STARVE + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE);

    localparam logic [1:0] SRC_DP   = 2'd0;
    localparam logic [1:0] SRC_WB   = 2'd1;
    localparam logic [1:0] SRC_HOST = 2'd2;
    localparam logic [1:0] SRC_INIT = 2'd3;

    typedef enum logic [1:0] {
        S_INIT     = 2'd0,
        S_IDLE     = 2'd1,
        S_WB_BURST = 2'd2,
        S_HRD      = 2'd3
    } state_t;

    // Burst length 0 behaves as 1 and anything past 4 as 4.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        if (len == 3'd0)
            return 3'd1;
        else if (len > 3'd4)
            return 3'd4;
        else
            return len;
    endfunction

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
        return (age == AGE_MAX) ? age : age + AGE_W'(1);
    endfunction

    state_t          state_q, state_d;
    logic [AW-1:0]   init_ptr_q, init_ptr_d;
    logic            init_done_q, init_done_d;
    logic [2:0]      beat_q, beat_d;
    logic [2:0]      len_q, len_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic            hrd_ph_q, hrd_ph_d;
    logic            wb_gnt_q, wb_gnt_d;
    logic            wb_done_q, wb_done_d;
    logic            host_rvalid_q, host_rvalid_d;
    logic [DW-1:0]   host_rdata_q, host_rdata_d;
    logic            om_en_q, om_en_d;
    logic            om_we_q, om_we_d;
    logic [AW-1:0]   om_addr_q, om_addr_d;
    logic [DW-1:0]   om_wdata_q, om_wdata_d;
    logic [1:0]      omsrc_q, omsrc_d;

    logic in_idle, host_starved, dp_acc, wb_acc, host_acc, wb_beat, wb_last;

    assign in_idle      = (state_q == S_IDLE);
    assign host_starved = in_idle && HOST_RD && (age_q == AGE_MAX);
    // A starved host outranks everything; otherwise host reads only win an idle port.
    assign dp_acc   = in_idle && !CLR_DP && !host_starved && DP_WE;
    assign wb_acc   = in_idle && !CLR_DP && !host_starved && !DP_WE && WB_REQ;
    assign host_acc = in_idle && !CLR_DP && HOST_RD && (host_starved || (!DP_WE && !WB_REQ));
    assign wb_beat  = (state_q == S_WB_BURST) && !CLR_DP && WB_EN;
    assign wb_last  = wb_beat && ((beat_q + 3'd1) == len_q);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= S_INIT;
            init_ptr_q    <= '0;
            init_done_q   <= 1'b0;
            beat_q        <= '0;
            len_q         <= '0;
            age_q         <= '0;
            hrd_ph_q      <= 1'b0;
            wb_gnt_q      <= 1'b0;
            wb_done_q     <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            om_en_q       <= 1'b0;
            om_we_q       <= 1'b0;
            om_addr_q     <= '0;
            om_wdata_q    <= '0;
            omsrc_q       <= '0;
        end else begin
            state_q       <= state_d;
            init_ptr_q    <= init_ptr_d;
            init_done_q   <= init_done_d;
            beat_q        <= beat_d;
            len_q         <= len_d;
            age_q         <= age_d;
            hrd_ph_q      <= hrd_ph_d;
            wb_gnt_q      <= wb_gnt_d;
            wb_done_q     <= wb_done_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            om_en_q       <= om_en_d;
            om_we_q       <= om_we_d;
            om_addr_q     <= om_addr_d;
            om_wdata_q    <= om_wdata_d;
            omsrc_q       <= omsrc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (CLR_DP) begin
            state_d = S_INIT;
        end else begin
            case (state_q)
                S_INIT:     if (&init_ptr_q) state_d = S_IDLE;
                S_IDLE: begin
                    if (host_acc)
                        state_d = S_HRD;
                    else if (wb_acc)
                        state_d = S_WB_BURST;
                end
                S_WB_BURST: if (wb_last) state_d = S_IDLE;
                S_HRD:      if (hrd_ph_q) state_d = S_IDLE;
                default:    state_d = S_INIT;
            endcase
        end
    end

    always_comb begin
        init_ptr_d    = init_ptr_q;
        init_done_d   = init_done_q;
        beat_d        = beat_q;
        len_d         = len_q;
        hrd_ph_d      = 1'b0;
        wb_gnt_d      = 1'b0;
        wb_done_d     = 1'b0;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;
        om_en_d       = 1'b0;
        om_we_d       = 1'b0;
        om_addr_d     = om_addr_q;
        om_wdata_d    = om_wdata_q;
        omsrc_d       = omsrc_q;

        if (CLR_DP || !HOST_RD || host_acc || state_q == S_HRD)
            age_d = '0;
        else
            age_d = age_inc(age_q);

        if (CLR_DP) begin
            init_ptr_d  = '0;
            init_done_d = 1'b0;
            beat_d      = '0;
        end else begin
            case (state_q)
                S_INIT: begin
                    om_en_d    = 1'b1;
                    om_we_d    = 1'b1;
                    om_addr_d  = init_ptr_q;
                    om_wdata_d = '0;
                    omsrc_d    = SRC_INIT;
                    init_ptr_d = init_ptr_q + AW'(1);
                    if (&init_ptr_q)
                        init_done_d = 1'b1;
                end
                S_IDLE: begin
                    if (host_acc) begin
                        om_en_d   = 1'b1;
                        om_addr_d = HOST_ADDR;
                        omsrc_d   = SRC_HOST;
                    end else if (dp_acc) begin
                        om_en_d    = 1'b1;
                        om_we_d    = 1'b1;
                        om_addr_d  = DP_ADDR;
                        om_wdata_d = DP_WDATA;
                        omsrc_d    = SRC_DP;
                    end else if (wb_acc) begin
                        wb_gnt_d = 1'b1;
                        len_d    = clamp_len(WB_LEN);
                        beat_d   = '0;
                    end
                end
                S_WB_BURST: begin
                    if (wb_beat) begin
                        om_en_d    = 1'b1;
                        om_we_d    = 1'b1;
                        om_addr_d  = WB_ADDR;
                        om_wdata_d = WB_DATA;
                        omsrc_d    = SRC_WB;
                        beat_d     = beat_q + 3'd1;
                        wb_done_d  = wb_last;
                    end
                end
                S_HRD: begin
                    // Phase 0 waits out the memory read; phase 1 sees OM_RDATA.
                    hrd_ph_d = !hrd_ph_q;
                    if (hrd_ph_q) begin
                        host_rvalid_d = 1'b1;
                        host_rdata_d  = OM_RDATA;
                    end
                end
                default: ;
            endcase
        end
    end

    assign DP_STALL    = !in_idle || host_starved;
    assign WB_GNT      = wb_gnt_q;
    assign WB_DONE     = wb_done_q;
    assign HOST_RVALID = host_rvalid_q;
    assign HOST_RDATA  = host_rdata_q;
    assign OM_EN       = om_en_q;
    assign OM_WE       = om_we_q;
    assign OM_ADDR     = om_addr_q;
    assign OM_WDATA    = om_wdata_q;
    assign OMSRC       = omsrc_q;
    assign INIT_DONE   = init_done_q;

endmodule

// File: tb/tb_om_port_arbiter.sv
// Directed bench for om_port_arbiter with a behavioural 16x64 memory on the port.
module tb_om_port_arbiter;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        CLR_DP;
    logic        DP_WE;
    logic [3:0]  DP_ADDR;
    logic [63:0] DP_WDATA;
    logic        DP_STALL;
    logic        WB_REQ;
    logic [2:0]  WB_LEN;
    logic        WB_GNT;
    logic        WB_EN;
    logic [3:0]  WB_ADDR;
    logic [63:0] WB_DATA;
    logic        WB_DONE;
    logic        HOST_RD;
    logic [3:0]  HOST_ADDR;
    logic        HOST_RVALID;
    logic [63:0] HOST_RDATA;
    logic        OM_EN;
    logic        OM_WE;
    logic [3:0]  OM_ADDR;
    logic [63:0] OM_WDATA;
    logic [63:0] OM_RDATA;
    logic [1:0]  OMSRC;
    logic        INIT_DONE;

    int checks = 0;
    int errors = 0;

    logic [63:0] mem [16];

    om_port_arbiter #(.AW(4), .DW(64), .STARVE(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .CLR_DP(CLR_DP),
        .DP_WE(DP_WE), .DP_ADDR(DP_ADDR), .DP_WDATA(DP_WDATA), .DP_STALL(DP_STALL),
        .WB_REQ(WB_REQ), .WB_LEN(WB_LEN), .WB_GNT(WB_GNT), .WB_EN(WB_EN),
        .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA), .WB_DONE(WB_DONE),
        .HOST_RD(HOST_RD), .HOST_ADDR(HOST_ADDR), .HOST_RVALID(HOST_RVALID),
        .HOST_RDATA(HOST_RDATA),
        .OM_EN(OM_EN), .OM_WE(OM_WE), .OM_ADDR(OM_ADDR), .OM_WDATA(OM_WDATA),
        .OM_RDATA(OM_RDATA), .OMSRC(OMSRC), .INIT_DONE(INIT_DONE)
    );

    always #5 CLK = ~CLK;

    // Synchronous memory: read data appears the cycle after a read enable.
    always @(posedge CLK) begin
        if (OM_EN) begin
            if (OM_WE)
                mem[OM_ADDR] <= OM_WDATA;
            else
                OM_RDATA <= mem[OM_ADDR];
        end
    end

    int          dp_addr_tab [4] = '{3, 4, 5, 7};
    logic [63:0] dp_data_tab [4] = '{64'h1111_0000_0000_0003, 64'h1111_0000_0000_0004,
                                     64'h1111_0000_0000_0005, 64'h0000_0000_0000_00A5};

    // Burst with a one-cycle WB_EN gap before the third beat; index = cycle after grant.
    logic gnt_tab   [7] = '{0, 1, 0, 0, 0, 0, 0};
    logic omen_tab  [7] = '{0, 0, 1, 1, 0, 1, 1};
    int   addr_tab  [7] = '{0, 0, 8, 9, 0, 10, 11};
    logic done_tab  [7] = '{0, 0, 0, 0, 0, 0, 1};
    logic stall_tab [7] = '{0, 1, 1, 1, 1, 1, 0};
    logic en_tab    [7] = '{0, 1, 1, 0, 1, 1, 0};
    int   drv_tab   [7] = '{0, 8, 9, 0, 10, 11, 0};

    task automatic test_reset();
        repeat (3) @(negedge CLK);
        checks++;
        if (DP_STALL !== 1'b1) begin
            errors++; $display("FAIL reset_stall: got %b expected 1", DP_STALL);
        end
        checks++;
        if ({OM_EN, OM_WE, OMSRC} !== 4'b0000) begin
            errors++; $display("FAIL reset_om: got %b expected 0000", {OM_EN, OM_WE, OMSRC});
        end
        checks++;
        if ({INIT_DONE, WB_GNT, WB_DONE, HOST_RVALID} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000",
                               {INIT_DONE, WB_GNT, WB_DONE, HOST_RVALID});
        end
        checks++;
        if (HOST_RDATA !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", HOST_RDATA);
        end
    endtask

    task automatic test_init_sweep();
        logic [7:0] exp;
        RSTN = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge CLK);
            exp = {1'b1, 1'b1, 4'(i - 1), 2'd3};
            checks++;
            if ({OM_EN, OM_WE, OM_ADDR, OMSRC} !== exp || OM_WDATA !== 64'h0) begin
                errors++; $display("FAIL init_write[%0d]: got %h/%h expected %h/0", i,
                                   {OM_EN, OM_WE, OM_ADDR, OMSRC}, OM_WDATA, exp);
            end
            checks++;
            if (INIT_DONE !== (i == 16)) begin
                errors++; $display("FAIL init_done[%0d]: got %b expected %b", i, INIT_DONE, i == 16);
            end
            checks++;
            if (DP_STALL !== (i != 16)) begin
                errors++; $display("FAIL init_stall[%0d]: got %b expected %b", i, DP_STALL, i != 16);
            end
        end
    endtask

    task automatic test_dp_writes();
        logic [7:0] exp;
        for (int i = 0; i <= 4; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                exp = {1'b1, 1'b1, 4'(dp_addr_tab[i-1]), 2'd0};
                checks++;
                if ({OM_EN, OM_WE, OM_ADDR, OMSRC} !== exp || OM_WDATA !== dp_data_tab[i-1]) begin
                    errors++; $display("FAIL dp_write[%0d]: got %h/%h expected %h/%h", i - 1,
                                       {OM_EN, OM_WE, OM_ADDR, OMSRC}, OM_WDATA, exp, dp_data_tab[i-1]);
                end
            end
            if (i < 4) begin
                DP_WE = 1'b1; DP_ADDR = 4'(dp_addr_tab[i]); DP_WDATA = dp_data_tab[i];
                #1;
                checks++;
                if (DP_STALL !== 1'b0) begin
                    errors++; $display("FAIL dp_stall[%0d]: got %b expected 0", i, DP_STALL);
                end
            end else begin
                DP_WE = 1'b0;
            end
        end
    endtask

    task automatic test_wb_burst();
        logic [7:0] exp;
        @(negedge CLK);
        WB_REQ = 1'b1; WB_LEN = 3'd4;
        DP_WE = 1'b1; DP_ADDR = 4'd2; DP_WDATA = 64'h2222;
        @(negedge CLK);
        checks++;
        if ({OM_EN, OM_WE, OM_ADDR, OMSRC} !== {1'b1, 1'b1, 4'd2, 2'd0} || WB_GNT !== 1'b0) begin
            errors++; $display("FAIL dp_over_wb: got %h gnt %b expected %h gnt 0",
                               {OM_EN, OM_WE, OM_ADDR, OMSRC}, WB_GNT, {1'b1, 1'b1, 4'd2, 2'd0});
        end
        DP_WE = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            checks++;
            if (WB_GNT !== gnt_tab[k]) begin
                errors++; $display("FAIL wb_gnt[%0d]: got %b expected %b", k, WB_GNT, gnt_tab[k]);
            end
            checks++;
            if (OM_EN !== omen_tab[k]) begin
                errors++; $display("FAIL wb_om_en[%0d]: got %b expected %b", k, OM_EN, omen_tab[k]);
            end
            if (omen_tab[k]) begin
                exp = {1'b1, 1'b1, 4'(addr_tab[k]), 2'd1};
                checks++;
                if ({OM_EN, OM_WE, OM_ADDR, OMSRC} !== exp || OM_WDATA !== 64'hB000 + 64'(addr_tab[k])) begin
                    errors++; $display("FAIL wb_write[%0d]: got %h/%h expected %h/%h", k,
                                       {OM_EN, OM_WE, OM_ADDR, OMSRC}, OM_WDATA, exp,
                                       64'hB000 + 64'(addr_tab[k]));
                end
            end
            checks++;
            if (WB_DONE !== done_tab[k]) begin
                errors++; $display("FAIL wb_done[%0d]: got %b expected %b", k, WB_DONE, done_tab[k]);
            end
            if (k == 1) WB_REQ = 1'b0;
            WB_EN = en_tab[k]; WB_ADDR = 4'(drv_tab[k]); WB_DATA = 64'hB000 + 64'(drv_tab[k]);
            #1;
            checks++;
            if (DP_STALL !== stall_tab[k]) begin
                errors++; $display("FAIL wb_stall[%0d]: got %b expected %b", k, DP_STALL, stall_tab[k]);
            end
        end
    endtask

    task automatic test_wb_len_clamp();
        @(negedge CLK);
        WB_REQ = 1'b1; WB_LEN = 3'd0;
        @(negedge CLK);
        checks++;
        if (WB_GNT !== 1'b1) begin
            errors++; $display("FAIL len0_gnt: got %b expected 1", WB_GNT);
        end
        WB_REQ = 1'b0; WB_EN = 1'b1; WB_ADDR = 4'd12; WB_DATA = 64'hC0C0;
        @(negedge CLK);
        checks++;
        if ({OM_EN, OM_WE, OM_ADDR, OMSRC, WB_DONE} !== {1'b1, 1'b1, 4'd12, 2'd1, 1'b1}) begin
            errors++; $display("FAIL len0_beat: got %h expected %h",
                               {OM_EN, OM_WE, OM_ADDR, OMSRC, WB_DONE}, {1'b1, 1'b1, 4'd12, 2'd1, 1'b1});
        end
        WB_ADDR = 4'd13;
        @(negedge CLK);
        checks++;
        if ({OM_EN, WB_DONE} !== 2'b00) begin
            errors++; $display("FAIL len0_extra_beat: got %b expected 00", {OM_EN, WB_DONE});
        end
        WB_EN = 1'b0;
    endtask

    task automatic test_host_read();
        @(negedge CLK);
        HOST_RD = 1'b1; HOST_ADDR = 4'd7;
        @(negedge CLK);
        checks++;
        if ({OM_EN, OM_WE, OM_ADDR, OMSRC} !== {1'b1, 1'b0, 4'd7, 2'd2}) begin
            errors++; $display("FAIL host_om_read: got %h expected %h",
                               {OM_EN, OM_WE, OM_ADDR, OMSRC}, {1'b1, 1'b0, 4'd7, 2'd2});
        end
        @(negedge CLK);
        checks++;
        if (HOST_RVALID !== 1'b0) begin
            errors++; $display("FAIL host_early_valid: got %b expected 0", HOST_RVALID);
        end
        @(negedge CLK);
        checks++;
        if (HOST_RVALID !== 1'b1 || HOST_RDATA !== 64'hA5) begin
            errors++; $display("FAIL host_rvalid: got %b/%h expected 1/a5", HOST_RVALID, HOST_RDATA);
        end
        HOST_RD = 1'b0;
        @(negedge CLK);
        checks++;
        if (HOST_RVALID !== 1'b0 || HOST_RDATA !== 64'hA5) begin
            errors++; $display("FAIL host_hold: got %b/%h expected 0/a5", HOST_RVALID, HOST_RDATA);
        end
    endtask

    task automatic test_starvation();
        int   lost = 0;
        logic stalled = 1'b0;
        @(negedge CLK);
        HOST_RD = 1'b1; HOST_ADDR = 4'd5;
        DP_WE = 1'b1; DP_ADDR = 4'd9; DP_WDATA = 64'h9999;
        for (int i = 0; i < 16 && !stalled; i++) begin
            if (i > 0) @(negedge CLK);
            #1;
            if (DP_STALL) stalled = 1'b1;
            else lost++;
        end
        checks++;
        if (stalled !== 1'b1 || lost != 8) begin
            errors++; $display("FAIL starve_lost: got stall %b after %0d cycles expected 1 after 8", stalled, lost);
        end
        @(negedge CLK);
        checks++;
        if ({OM_EN, OM_WE, OM_ADDR, OMSRC} !== {1'b1, 1'b0, 4'd5, 2'd2}) begin
            errors++; $display("FAIL starve_om_read: got %h expected %h",
                               {OM_EN, OM_WE, OM_ADDR, OMSRC}, {1'b1, 1'b0, 4'd5, 2'd2});
        end
        #1;
        checks++;
        if (DP_STALL !== 1'b1) begin
            errors++; $display("FAIL starve_hrd_stall: got %b expected 1", DP_STALL);
        end
        repeat (2) @(negedge CLK);
        checks++;
        if (HOST_RVALID !== 1'b1 || HOST_RDATA !== 64'h1111_0000_0000_0005) begin
            errors++; $display("FAIL starve_rvalid: got %b/%h expected 1/1111000000000005",
                               HOST_RVALID, HOST_RDATA);
        end
        HOST_RD = 1'b0; DP_WE = 1'b0;
    endtask

    task automatic test_clear_mid_burst();
        int cnt = 0;
        @(negedge CLK);
        WB_REQ = 1'b1; WB_LEN = 3'd4;
        @(negedge CLK);
        checks++;
        if (WB_GNT !== 1'b1) begin
            errors++; $display("FAIL clr_gnt: got %b expected 1", WB_GNT);
        end
        WB_REQ = 1'b0; WB_EN = 1'b1; WB_ADDR = 4'd13; WB_DATA = 64'hD13;
        @(negedge CLK);
        checks++;
        if ({OM_EN, OM_WE, OM_ADDR, OMSRC} !== {1'b1, 1'b1, 4'd13, 2'd1}) begin
            errors++; $display("FAIL clr_beat1: got %h expected %h",
                               {OM_EN, OM_WE, OM_ADDR, OMSRC}, {1'b1, 1'b1, 4'd13, 2'd1});
        end
        WB_ADDR = 4'd14; WB_DATA = 64'hD14; CLR_DP = 1'b1;
        @(negedge CLK);
        checks++;
        if ({OM_EN, WB_DONE, INIT_DONE} !== 3'b000) begin
            errors++; $display("FAIL clr_abort: got en/done/init %b expected 000", {OM_EN, WB_DONE, INIT_DONE});
        end
        CLR_DP = 1'b0; WB_ADDR = 4'd15; WB_DATA = 64'hD15;
        @(negedge CLK);
        checks++;
        if ({OM_EN, OM_WE, OM_ADDR, OMSRC, WB_DONE} !== {1'b1, 1'b1, 4'd0, 2'd3, 1'b0} || OM_WDATA !== 64'h0) begin
            errors++; $display("FAIL clr_restart: got %h/%h expected %h/0",
                               {OM_EN, OM_WE, OM_ADDR, OMSRC, WB_DONE}, OM_WDATA,
                               {1'b1, 1'b1, 4'd0, 2'd3, 1'b0});
        end
        WB_EN = 1'b0;
        while (!INIT_DONE && cnt < 40) begin
            @(negedge CLK);
            cnt++;
        end
        checks++;
        if (INIT_DONE !== 1'b1 || cnt != 15 || OM_ADDR !== 4'd15) begin
            errors++; $display("FAIL clr_sweep_done: got done %b after %0d cycles at addr %0d expected 1 after 15 at 15",
                               INIT_DONE, cnt, OM_ADDR);
        end
    endtask

    initial begin
        RSTN = 1'b0; CLR_DP = 1'b0;
        DP_WE = 1'b0; DP_ADDR = '0; DP_WDATA = '0;
        WB_REQ = 1'b0; WB_LEN = '0; WB_EN = 1'b0; WB_ADDR = '0; WB_DATA = '0;
        HOST_RD = 1'b0; HOST_ADDR = '0;
        test_reset();
        test_init_sweep();
        test_dp_writes();
        test_wb_burst();
        test_wb_len_clamp();
        test_host_read();
        test_starvation();
        test_clear_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
